instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4: instruction buffer entries; power of two, >=2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_req_addr  output  32  word-aligned fetch address; bits[1:0] always 0.
REQ-008 imem_resp_valid  input  1  response valid; responses in request order, no backpressure, latency >=1 cycle.
REQ-009 imem_resp_data  input  32  fetched instruction word.
REQ-010 redirect_valid  input  1  taken branch/jump: flush and restart fetch.
REQ-011 redirect_pc  input  32  restart target; bits[1:0] ignored and forced to 0.
REQ-012 out_valid  output  1  instruction available to decode.
REQ-013 out_ready  input  1  decode accepts the instruction.
REQ-014 out_instr  output  32  instruction word for decode and immediate generation; NOP (32'h0000_0013) when out_valid=0.
REQ-015 out_pc  output  32  address of out_instr.

Function
REQ-016 A request fires when imem_req_valid && imem_req_ready; on fire, fetch_pc advances by 4, wrapping from 32'hFFFF_FFFC to 0.
REQ-017 imem_req_valid SHALL be high iff rst=0, redirect_valid=0, and outstanding + fifo_count < FIFO_DEPTH; the buffer therefore never overflows.
REQ-018 The outstanding counter SHALL increment on fire and decrement on imem_resp_valid; it SHALL stay unchanged when both occur in the same cycle.
REQ-019 Each fired address SHALL be pushed to an in-flight PC queue, then popped and paired with its in-order response.
REQ-020 A non-stale response SHALL be written to the buffer as {instr, pc}; out_valid rises the cycle after the write, with no bypass.
REQ-021 out_valid = buffer not empty; head pops when out_valid && out_ready; push and pop in the same cycle leave the count unchanged.
REQ-022 Throughput SHALL be one instruction per cycle when memory latency is 1, out_ready is held high, and FIFO_DEPTH >= 4.
REQ-023 On redirect_valid, the same edge SHALL empty the buffer and in-flight queue, load fetch_pc with {redirect_pc[31:2],2'b00}, and set drop_count to outstanding - imem_resp_valid.
REQ-024 Responses arriving while drop_count > 0 SHALL be discarded and decrement drop_count; a response arriving in the redirect cycle itself is discarded.
REQ-025 Redirect overrides a simultaneous pop, push, or request; no request fires in the redirect cycle.
REQ-026 A redirect while drop_count > 0 SHALL recompute drop_count per REQ-023; it SHALL NOT accumulate.
REQ-027 After redirect, the first request SHALL issue the next cycle with address redirect target, independent of drop_count.

Reset
REQ-028 During rst: imem_req_valid=0, out_valid=0, out_instr=NOP, out_pc=0, fetch_pc=RESET_PC, and outstanding, drop_count and buffer are cleared.
REQ-029 The first request SHALL assert in the first cycle after rst deasserts, with address RESET_PC.
REQ-030 Reset mid-operation SHALL abandon all in-flight requests; instruction memory is reset in the same cycles and returns no stale responses.

Structure
REQ-031 Shared package rv32i_pkg SHALL hold XLEN=32, the NOP encoding, and the default reset PC; the instruction opcode constants used by immediate generation belong in the same package.
REQ-032 The instruction buffer and the in-flight PC queue SHALL each be an instance of one sub-module, sync_fifo (parameterised width and depth, with a synchronous flush).

Verification
REQ-033 Reset then 1-cycle memory, out_ready=1 -> out_pc sequence 0,4,8,12 on consecutive cycles; first out_valid three cycles after reset release.
REQ-034 out_ready=0 for 10 cycles -> at most 4 buffered, imem_req_valid low once credits exhausted; releasing ready delivers all PCs in order with no gaps or duplicates.
REQ-035 Redirect to 32'h0000_0102 with 2 requests outstanding -> both responses dropped, next out_pc=32'h0000_0100, next imem_req_addr=32'h0000_0100.
REQ-036 Redirect in the same cycle as imem_resp_valid and out_ready -> response discarded, out_valid=0 next cycle.
REQ-037 fetch_pc=32'hFFFF_FFF8, out_ready=1 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 rst asserted mid-stream with buffer non-empty -> out_valid=0 next cycle; restart at RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: datapath width, NOP encoding, default reset vector, base opcodes
// and the instruction-buffer entry layout used by the fetch stage.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Major opcodes (instr[6:0]) consumed by immediate generation.
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Sequential fetch step; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush. Depth must be a power of two so the
// pointers wrap naturally; push is ignored when full and pop when empty.
module sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, wptr_d;
  logic [AddrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AddrW'(1);
      if (do_pop)  rptr_d = rptr_q + AddrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: credit-limited request issue, in-order response pairing with
// fetched PCs, a decode-side instruction buffer, and redirect flush with stale-response drop.
module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SumW = CntW + 1;
  localparam logic [SumW-1:0] DepthSum = SumW'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] drop_q, drop_d;

  logic            credit_ok;
  logic            req_fire;
  logic            resp_keep, resp_drop;
  logic            buf_pop;

  fetch_entry_t    buf_wdata, buf_rdata;
  logic            buf_empty, buf_full;
  logic [CntW-1:0] buf_count;

  logic [XLEN-1:0] pcq_rdata;
  logic            pcq_empty, pcq_full;
  logic [CntW-1:0] pcq_count;

  logic            unused_sigs;

  // Credits cover both in-flight requests and buffered entries, so the buffer cannot overflow.
  assign credit_ok      = ({1'b0, outst_q} + {1'b0, buf_count}) < DepthSum;
  assign imem_req_valid = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response in the redirect cycle belongs to the old stream and is simply not kept.
  assign resp_keep = imem_resp_valid && !redirect_valid && (drop_q == '0);
  assign resp_drop = imem_resp_valid && !redirect_valid && (drop_q != '0);

  assign out_valid = !rst && !buf_empty;
  assign out_instr = out_valid ? buf_rdata.instr : NOP_INSTR;
  assign out_pc    = out_valid ? buf_rdata.pc : '0;
  assign buf_pop   = out_valid && out_ready && !redirect_valid;

  assign buf_wdata.instr = imem_resp_data;
  assign buf_wdata.pc    = pcq_rdata;

  sync_fifo #(
    .Width(XLEN),
    .Depth(FIFO_DEPTH),
    .CntW (CntW)
  ) u_pc_queue (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(redirect_valid),
    .push_i (req_fire),
    .wdata_i(fetch_pc_q),
    .pop_i  (resp_keep),
    .rdata_o(pcq_rdata),
    .empty_o(pcq_empty),
    .full_o (pcq_full),
    .count_o(pcq_count)
  );

  sync_fifo #(
    .Width($bits(fetch_entry_t)),
    .Depth(FIFO_DEPTH),
    .CntW (CntW)
  ) u_instr_buf (
    .clk_i  (clk),
    .rst_i  (rst),
    .flush_i(redirect_valid),
    .push_i (resp_keep),
    .wdata_i(buf_wdata),
    .pop_i  (buf_pop),
    .rdata_o(buf_rdata),
    .empty_o(buf_empty),
    .full_o (buf_full),
    .count_o(buf_count)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    unique case ({req_fire, imem_resp_valid})
      2'b10:   outst_d = outst_q + CntW'(1);
      2'b01:   outst_d = outst_q - CntW'(1);
      default: outst_d = outst_q;
    endcase
    if (redirect_valid) begin
      // Everything still outstanding after this edge is stale; recomputed, never accumulated.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drop_d     = outst_q - CntW'(imem_resp_valid);
    end else begin
      if (req_fire)  fetch_pc_d = pc_incr(fetch_pc_q);
      if (resp_drop) drop_d     = drop_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  assign unused_sigs = ^{redirect_pc[1:0], buf_full, pcq_empty, pcq_full, pcq_count};

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: variable-latency in-order memory model plus an
// output scoreboard fed from a reference fetch-PC model.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int unsigned cyc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;

  int checks = 0;
  int errors = 0;

  int unsigned cyc = 0;
  int unsigned mem_lat = 1;
  logic [31:0] mq_addr[$];
  int unsigned mq_due[$];

  logic [31:0] model_pc = RST_PC;
  obs_t        exp_q[$];
  obs_t        obs_q[$];
  logic [31:0] addr_exp_q[$];
  logic [31:0] addr_obs_q[$];
  obs_t        mon_e;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC  (RST_PC),
    .FIFO_DEPTH(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model, reference PC model and output monitor share one block to avoid races.
  always @(posedge clk) begin
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      imem_resp_valid <= 1'b0;
      exp_q.delete();
      model_pc = RST_PC;
    end else begin
      if (imem_resp_valid) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + mem_lat);
      end
      imem_resp_valid <= (mq_addr.size() > 0) && (mq_due[0] <= cyc + 1);
      imem_resp_data  <= (mq_addr.size() > 0) ? mem_word(mq_addr[0]) : 32'h0;
      if (redirect_valid) begin
        exp_q.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          addr_obs_q.push_back(imem_req_addr);
          addr_exp_q.push_back(model_pc);
          mon_e.pc    = model_pc;
          mon_e.instr = mem_word(model_pc);
          mon_e.cyc   = 0;
          exp_q.push_back(mon_e);
          model_pc = model_pc + 32'd4;
        end
        if (out_valid && out_ready) begin
          mon_e.pc    = out_pc;
          mon_e.instr = out_instr;
          mon_e.cyc   = cyc;
          obs_q.push_back(mon_e);
        end
      end
    end
    cyc = cyc + 1;
  end

  task automatic test_reset();
    rst = 1'b1;
    mem_lat = 1;
    repeat (3) @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_instr !== NOP) begin errors++; $display("FAIL reset_out_instr got %h want %h", out_instr, NOP); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
  endtask

  task automatic test_stream();
    int unsigned rel;
    obs_t o, e;
    obs_q.delete();
    rst = 1'b0;
    rel = cyc;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin errors++; $display("FAIL stream_first_req got %b/%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC); end
    repeat (8) @(negedge clk);
    checks++;
    if (obs_q.size() < 4) begin errors++; $display("FAIL stream_count got %0d want >=4", obs_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_q[i].pc !== 32'(4 * i) || obs_q[i].cyc !== rel + 2 + i) begin
          errors++; $display("FAIL stream_seq[%0d] got pc %h cyc %0d want pc %h cyc %0d", i, obs_q[i].pc, obs_q[i].cyc, 32'(4 * i), rel + 2 + i);
        end
      end
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL stream_order got pc %h want none", o.pc); end
      else begin
        e = exp_q.pop_front();
        if (o.pc !== e.pc || o.instr !== e.instr) begin errors++; $display("FAIL stream_order got %h/%h want %h/%h", o.pc, o.instr, e.pc, e.instr); end
      end
    end
  endtask

  task automatic test_backpressure();
    int unsigned rel;
    obs_t o, e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL bp_pre_order got pc %h want none", o.pc); end
      else begin
        e = exp_q.pop_front();
        if (o.pc !== e.pc || o.instr !== e.instr) begin errors++; $display("FAIL bp_pre_order got %h/%h want %h/%h", o.pc, o.instr, e.pc, e.instr); end
      end
    end
    out_ready = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stalled got %b want 0", imem_req_valid); end
    checks++; if (exp_q.size() != 4) begin errors++; $display("FAIL bp_in_flight got %0d want 4", exp_q.size()); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL bp_no_output got %0d want 0", obs_q.size()); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b want 1", out_valid); end
    out_ready = 1'b1;
    rel = cyc;
    repeat (12) @(negedge clk);
    checks++;
    if (obs_q.size() < 8) begin errors++; $display("FAIL bp_release_count got %0d want >=8", obs_q.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs_q[i].cyc !== rel + i) begin errors++; $display("FAIL bp_no_gap[%0d] got cyc %0d want %0d", i, obs_q[i].cyc, rel + i); end
      end
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL bp_order got pc %h want none", o.pc); end
      else begin
        e = exp_q.pop_front();
        if (o.pc !== e.pc || o.instr !== e.instr) begin errors++; $display("FAIL bp_order got %h/%h want %h/%h", o.pc, o.instr, e.pc, e.instr); end
      end
    end
  endtask

  task automatic test_redirect();
    obs_t o, e;
    logic [31:0] a, b;
    mem_lat = 2;
    repeat (6) @(negedge clk);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL redir_pre_order got pc %h want none", o.pc); end
      else begin
        e = exp_q.pop_front();
        if (o.pc !== e.pc || o.instr !== e.instr) begin errors++; $display("FAIL redir_pre_order got %h/%h want %h/%h", o.pc, o.instr, e.pc, e.instr); end
      end
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_no_req got %b want 0", imem_req_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_flushed got %b want 0", out_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0100) begin errors++; $display("FAIL redir_next_req got %b/%h want 1/00000100", imem_req_valid, imem_req_addr); end
    repeat (8) @(negedge clk);
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL redir_first_out got none want pc 00000100"); end
    else if (obs_q[0].pc !== 32'h0000_0100 || obs_q[0].instr !== mem_word(32'h0000_0100)) begin
      errors++; $display("FAIL redir_first_out got %h/%h want 00000100/%h", obs_q[0].pc, obs_q[0].instr, mem_word(32'h0000_0100));
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL redir_order got pc %h want none", o.pc); end
      else begin
        e = exp_q.pop_front();
        if (o.pc !== e.pc || o.instr !== e.instr) begin errors++; $display("FAIL redir_order got %h/%h want %h/%h", o.pc, o.instr, e.pc, e.instr); end
      end
    end
    while (addr_obs_q.size() > 0) begin
      a = addr_obs_q.pop_front(); b = addr_exp_q.pop_front(); checks++;
      if (a !== b) begin errors++; $display("FAIL redir_addr got %h want %h", a, b); end
    end
  endtask

  task automatic test_redirect_resp();
    obs_t o, e;
    mem_lat = 1;
    repeat (4) @(negedge clk);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL rresp_pre_order got pc %h want none", o.pc); end
      else begin
        e = exp_q.pop_front();
        if (o.pc !== e.pc || o.instr !== e.instr) begin errors++; $display("FAIL rresp_pre_order got %h/%h want %h/%h", o.pc, o.instr, e.pc, e.instr); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rresp_busy got %b want 1", out_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rresp_discard got %b want 0", out_valid); end
    repeat (6) @(negedge clk);
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL rresp_first_out got none want pc 00000200"); end
    else if (obs_q[0].pc !== 32'h0000_0200) begin errors++; $display("FAIL rresp_first_out got %h want 00000200", obs_q[0].pc); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL rresp_order got pc %h want none", o.pc); end
      else begin
        e = exp_q.pop_front();
        if (o.pc !== e.pc || o.instr !== e.instr) begin errors++; $display("FAIL rresp_order got %h/%h want %h/%h", o.pc, o.instr, e.pc, e.instr); end
      end
    end
  endtask

  task automatic test_double_redirect();
    obs_t o, e;
    mem_lat = 3;
    repeat (6) @(negedge clk);
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL dredir_pre_order got pc %h want none", o.pc); end
      else begin
        e = exp_q.pop_front();
        if (o.pc !== e.pc || o.instr !== e.instr) begin errors++; $display("FAIL dredir_pre_order got %h/%h want %h/%h", o.pc, o.instr, e.pc, e.instr); end
      end
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    @(negedge clk);
    redirect_pc = 32'h0000_0400;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (obs_q.size() < 3) begin errors++; $display("FAIL dredir_count got %0d want >=3", obs_q.size()); end
    else if (obs_q[0].pc !== 32'h0000_0400) begin errors++; $display("FAIL dredir_first_out got %h want 00000400", obs_q[0].pc); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL dredir_order got pc %h want none", o.pc); end
      else begin
        e = exp_q.pop_front();
        if (o.pc !== e.pc || o.instr !== e.instr) begin errors++; $display("FAIL dredir_order got %h/%h want %h/%h", o.pc, o.instr, e.pc, e.instr); end
      end
    end
  endtask

  task automatic test_wrap();
    obs_t o, e;
    logic [31:0] a, b;
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8;
    want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0000_0000;
    mem_lat = 1;
    repeat (4) @(negedge clk);
    while (addr_obs_q.size() > 0) begin
      a = addr_obs_q.pop_front(); b = addr_exp_q.pop_front(); checks++;
      if (a !== b) begin errors++; $display("FAIL wrap_pre_addr got %h want %h", a, b); end
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_pre_order got pc %h want none", o.pc); end
      else begin
        e = exp_q.pop_front();
        if (o.pc !== e.pc || o.instr !== e.instr) begin errors++; $display("FAIL wrap_pre_order got %h/%h want %h/%h", o.pc, o.instr, e.pc, e.instr); end
      end
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (addr_obs_q.size() < 3 || obs_q.size() < 3) begin
      errors++; $display("FAIL wrap_count got %0d/%0d want >=3/>=3", addr_obs_q.size(), obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (addr_obs_q[i] !== want[i] || obs_q[i].pc !== want[i]) begin
          errors++; $display("FAIL wrap_seq[%0d] got addr %h out %h want %h", i, addr_obs_q[i], obs_q[i].pc, want[i]);
        end
      end
    end
    while (addr_obs_q.size() > 0) begin
      a = addr_obs_q.pop_front(); b = addr_exp_q.pop_front(); checks++;
      if (a !== b) begin errors++; $display("FAIL wrap_addr got %h want %h", a, b); end
    end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_order got pc %h want none", o.pc); end
      else begin
        e = exp_q.pop_front();
        if (o.pc !== e.pc || o.instr !== e.instr) begin errors++; $display("FAIL wrap_order got %h/%h want %h/%h", o.pc, o.instr, e.pc, e.instr); end
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    out_ready = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_buffered got %b want 1", out_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_in_reset got %b want 0", out_valid); end
    rst = 1'b0;
    obs_q.delete();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_cleared got %b want 0", out_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin errors++; $display("FAIL rmid_restart got %b/%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC); end
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (obs_q.size() == 0) begin errors++; $display("FAIL rmid_first_out got none want pc %h", RST_PC); end
    else if (obs_q[0].pc !== RST_PC) begin errors++; $display("FAIL rmid_first_out got %h want %h", obs_q[0].pc, RST_PC); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL rmid_order got pc %h want none", o.pc); end
      else begin
        e = exp_q.pop_front();
        if (o.pc !== e.pc || o.instr !== e.instr) begin errors++; $display("FAIL rmid_order got %h/%h want %h/%h", o.pc, o.instr, e.pc, e.instr); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_resp();
    test_double_redirect();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
